seq_signed_div: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/seq_signed_div_if.sv | 37 +++
 rtl/div_step.sv | 30 +++
 rtl/seq_signed_div.sv | 144 ++++++++++++++
 tb/tb_seq_signed_div.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the default operand widths, the iteration-counter width and the
// controller state encoding used by seq_signed_div.
package div_pkg;

  localparam int WD_DEF = 8;                   // dividend / quotient width
  localparam int WS_DEF = 4;                   // divisor / remainder width
  localparam int CNT_W  = $clog2(WD_DEF + 1);  // iteration counter width

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    FIX_ZERO
  } state_t;

endpackage

// File: rtl/seq_signed_div_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
//   start       : request, sampled only while busy is low
//   dividend    : WD-bit signed dividend
//   divisor     : WS-bit signed divisor
//   busy        : operation in progress
//   done        : one-cycle completion pulse
//   quotient    : WD-bit signed quotient
//   remainder   : WS-bit signed remainder
//   div_by_zero : last result came from a zero divisor
//   overflow    : last result overflowed (most-negative / -1)
// master = requester side, slave = divider side.
interface seq_signed_div_if #(
  parameter int WD = div_pkg::WD_DEF,
  parameter int WS = div_pkg::WS_DEF
);

  logic                 start;
  logic signed [WD-1:0] dividend;
  logic signed [WS-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic signed [WD-1:0] quotient;
  logic signed [WS-1:0] remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step on magnitudes.
//   rem_i  : current partial remainder (always below the divisor magnitude)
//   bit_i  : next dividend-magnitude bit, MSB first
//   dvs_i  : divisor magnitude
//   rem_o  : next partial remainder
//   qbit_o : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WS = WS_DEF
) (
  input  logic [WS-1:0] rem_i,
  input  logic          bit_i,
  input  logic [WS-1:0] dvs_i,
  output logic [WS-1:0] rem_o,
  output logic          qbit_o
);

  // Working value is one bit wider than the held remainder: 2*rem+bit can
  // reach 2*|divisor|-1, which needs WS+1 bits.
  logic [WS:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, dvs_i});
    // A kept difference is below |divisor|, so it fits back in WS bits.
    rem_o   = qbit_o ? WS'(shifted - {1'b0, dvs_i}) : shifted[WS-1:0];
  end

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider, restoring algorithm, one quotient bit per clock.
// Truncates toward zero; the remainder carries the dividend's sign.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts an operation in flight)
//   bus   : seq_signed_div_if slave port (start/busy/done handshake,
//           operands, quotient, remainder, div_by_zero, overflow)
// Start accepted at edge k gives done after edge k+WD+1, or after k+1 for a
// zero divisor. Results and flags hold until the next completion.
module seq_signed_div
  import div_pkg::*;
#(
  parameter int WD = WD_DEF,
  parameter int WS = WS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_signed_div_if.slave      bus
);

  // Control and result registers (reset)
  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic signed [WD-1:0] quot_q;
  logic signed [WS-1:0] rem_q;
  logic                 dbz_q;
  logic                 ovf_q;

  // Datapath registers (not reset; only meaningful while busy)
  logic [WD-1:0]        dvd_q;       // dividend magnitude, refilled with quotient bits
  logic [WS-1:0]        dvs_q;       // divisor magnitude
  logic [WS-1:0]        prem_q;      // partial remainder
  logic                 neg_quot_q;
  logic                 neg_rem_q;

  logic [WS-1:0]        prem_d;
  logic                 qbit_d;
  logic signed [WD-1:0] quot_fix_d;
  logic signed [WS-1:0] rem_fix_d;
  logic                 ovf_d;
  logic                 accept;

  function automatic logic [WD-1:0] mag_wd(input logic signed [WD-1:0] v);
    return v[WD-1] ? WD'(-v) : WD'(v);
  endfunction

  function automatic logic [WS-1:0] mag_ws(input logic signed [WS-1:0] v);
    return v[WS-1] ? WS'(-v) : WS'(v);
  endfunction

  function automatic logic signed [WD-1:0] sign_wd(input logic [WD-1:0] m, input logic neg);
    return neg ? -m : m;
  endfunction

  function automatic logic signed [WS-1:0] sign_ws(input logic [WS-1:0] m, input logic neg);
    return neg ? -m : m;
  endfunction

  div_step #(.WS(WS)) u_step (
    .rem_i  (prem_q),
    .bit_i  (dvd_q[WD-1]),
    .dvs_i  (dvs_q),
    .rem_o  (prem_d),
    .qbit_o (qbit_d)
  );

  assign accept     = (state_q == IDLE) && bus.start;
  assign quot_fix_d = sign_wd(dvd_q, neg_quot_q);
  assign rem_fix_d  = sign_ws(prem_q, neg_rem_q);
  // A magnitude quotient of 2^(WD-1) only arises from |dividend|=2^(WD-1)
  // and |divisor|=1; it is representable only when the result is negative.
  assign ovf_d      = dvd_q[WD-1] & ~neg_quot_q;

  // Controller and result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= (bus.divisor == '0) ? FIX_ZERO : CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WD - 1)) state_q <= FIX;
        end
        FIX: begin
          quot_q  <= quot_fix_d;
          rem_q   <= rem_fix_d;
          ovf_q   <= ovf_d;
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        FIX_ZERO: begin
          quot_q  <= '1;
          rem_q   <= '0;
          ovf_q   <= 1'b0;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand capture and iteration stage
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q      <= mag_wd(bus.dividend);
      dvs_q      <= mag_ws(bus.divisor);
      prem_q     <= '0;
      neg_quot_q <= bus.dividend[WD-1] ^ bus.divisor[WS-1];
      neg_rem_q  <= bus.dividend[WD-1];
    end else if (state_q == CALC) begin
      dvd_q  <= {dvd_q[WD-2:0], qbit_d};
      prem_q <= prem_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_signed_div.sv
// Scoreboard bench for seq_signed_div: directed cases plus random operands,
// expected results from plain integer division.
module tb_seq_signed_div;
  import div_pkg::*;

  localparam int WD = WD_DEF;
  localparam int WS = WS_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_signed_div_if #(.WD(WD), .WS(WS)) bus();

  seq_signed_div #(.WD(WD), .WS(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WD-1:0] q;
    logic [WS-1:0] r;
    logic          dbz;
    logic          ovf;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: truncating integer division, remainder follows the dividend.
  function automatic exp_t model(input int a, input int b, input int due);
    exp_t e;
    int   q;
    int   r;
    e.due = due;
    if (b == 0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1; e.ovf = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      e.q   = q[WD-1:0];
      e.r   = r[WS-1:0];
      e.dbz = 1'b0;
      e.ovf = (q > 127) || (q < -128);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    32'($unsigned(bus.quotient)),  32'(e.q));
        check("remainder",   32'($unsigned(bus.remainder)), 32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero),          32'(e.dbz));
        check("overflow",    32'(bus.overflow),             32'(e.ovf));
        check("latency",     32'(cyc),                      32'(e.due));
      end
    end
  end

  // Call at a negedge while the divider is idle; returns at the next negedge.
  task automatic issue(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = a[WD-1:0];
    bus.divisor  = b[WS-1:0];
    @(negedge clk);
    sb.push_back(model(a, b, cyc + ((b == 0) ? 1 : WD + 1)));
    bus.start    = 1'b0;
    bus.dividend = WD'($urandom);
    bus.divisor  = WS'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      32'(bus.busy),                 32'd0);
    check({tag, "_done"},      32'(bus.done),                 32'd0);
    check({tag, "_quotient"},  32'($unsigned(bus.quotient)),  32'd0);
    check({tag, "_remainder"}, 32'($unsigned(bus.remainder)), 32'd0);
    check({tag, "_dbz"},       32'(bus.div_by_zero),          32'd0);
    check({tag, "_ovf"},       32'(bus.overflow),             32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int b;
    int n;
    int dn;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(100, 7);    wait_done(20);
    issue(-100, 7);   wait_done(20);
    issue(127, -8);   wait_done(20);
    issue(-128, -1);  wait_done(20);
    issue(6, 3);      wait_done(20);
    issue(25, 0);     wait_done(20);

    // Start held through busy is ignored, then taken on the done cycle
    issue(50, 5);
    bus.start    = 1'b1;
    bus.dividend = 8'sd99;
    bus.divisor  = 4'sd7;
    bus.divisor  = 4'sd9 - 4'sd9 + 4'sd1;
    bus.dividend = 8'sd99;
    bus.divisor  = 4'b1001;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      check("busy_during_calc", 32'(bus.busy), 32'd1);
      check("quotient_hold", 32'($unsigned(bus.quotient)), 32'hFF);
      @(negedge clk);
      n++;
    end
    check("done_seen_50_5", 32'(bus.done), 32'd1);
    sb.push_back(model(99, -7, cyc + 1 + WD + 1));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(20);

    // Reset in the middle of an operation
    issue(-77, 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("no_done_after_abort", 32'(dn), 32'd0);
    issue(-77, 3);
    wait_done(20);

    // Random back-to-back operations
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(255)) - 128;
      b = int'($urandom_range(15)) - 8;
      if (i % 8 == 3) b = 0;
      if (i % 8 == 5) begin a = -128; b = -1; end
      issue(a, b);
      wait_done(20);
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
